// File: rtl/aes_iter_sequencer.sv
// Iterative AES-128 encryption sequencer: one shared round datapath reused over Nr rounds,
// with round keys expanded on the fly and valid/ready handshakes on both sides.
module aes_iter_sequencer #(
   parameter int Nr = 10,
   parameter int Nk = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out,
   output logic         busy,
   output logic [3:0]   round_idx
);

   typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} fsm_t;

   localparam logic [3:0] LAST_ROUND = 4'(Nr);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
      return r;
   endfunction

   // Byte n sits at bits 127-8n; byte n holds row n%4 of column n/4.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++)
            r[8*(15-(4*c+w)) +: 8] = s[8*(15-(4*((c+w)%4)+w)) +: 8];
      return r;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[8*(15-4*c) +: 8];
         a1 = s[8*(14-4*c) +: 8];
         a2 = s[8*(13-4*c) +: 8];
         a3 = s[8*(12-4*c) +: 8];
         r[8*(15-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[8*(14-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[8*(13-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[8*(12-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

   function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
      return s ^ k;
   endfunction

   function automatic logic [127:0] encrypt_round(input logic [127:0] s, input logic [127:0] k);
      return add_round_key(mix_columns(shift_rows(sub_bytes(s))), k);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      case (rnd)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
      logic [31:0] last, t, n0, n1, n2, n3;
      last = rk[128-32*Nk +: 32];
      t  = {SBOX[last[23:16]], SBOX[last[15:8]], SBOX[last[7:0]], SBOX[last[31:24]]} ^ {rc, 24'h000000};
      n0 = rk[127:96] ^ t;
      n1 = rk[95:64] ^ n0;
      n2 = rk[63:32] ^ n1;
      n3 = rk[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   fsm_t         fsm_r, fsm_nxt_s;
   logic [127:0] state_r, state_nxt_s, rk_r, rk_nxt_s, next_rk_s, out_r, out_nxt_s;
   logic [3:0]   round_r, round_nxt_s;
   logic         out_valid_r, out_valid_nxt_s, in_ready_r, busy_r;

   // Next-state and datapath selection for the IDLE/ROUND/DONE sequencer
   always_comb begin
      fsm_nxt_s       = fsm_r;
      state_nxt_s     = state_r;
      rk_nxt_s        = rk_r;
      round_nxt_s     = round_r;
      out_nxt_s       = out_r;
      out_valid_nxt_s = out_valid_r;
      next_rk_s       = key_expand(rk_r, rcon(round_r));
      case (fsm_r)
         IDLE: begin
            if (in_valid && in_ready_r) begin
               state_nxt_s = in ^ key;
               rk_nxt_s    = key;
               round_nxt_s = 4'd1;
               fsm_nxt_s   = ROUND;
            end else begin
               fsm_nxt_s = IDLE;
            end
         end
         ROUND: begin
            rk_nxt_s = next_rk_s;
            if (round_r == LAST_ROUND) begin
               state_nxt_s     = add_round_key(shift_rows(sub_bytes(state_r)), next_rk_s);
               out_nxt_s       = state_nxt_s;
               out_valid_nxt_s = 1'b1;
               fsm_nxt_s       = DONE;
            end else begin
               state_nxt_s = encrypt_round(state_r, next_rk_s);
               round_nxt_s = round_r + 4'd1;
            end
         end
         DONE: begin
            if (out_valid_r && out_ready) begin
               out_valid_nxt_s = 1'b0;
               round_nxt_s     = 4'd0;
               fsm_nxt_s       = IDLE;
            end else begin
               fsm_nxt_s = DONE;
            end
         end
         default: begin
            out_valid_nxt_s = 1'b0;
            round_nxt_s     = 4'd0;
            fsm_nxt_s       = IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_r       <= IDLE;
         state_r     <= 128'd0;
         rk_r        <= 128'd0;
         round_r     <= 4'd0;
         out_r       <= 128'd0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         fsm_r       <= fsm_nxt_s;
         state_r     <= state_nxt_s;
         rk_r        <= rk_nxt_s;
         round_r     <= round_nxt_s;
         out_r       <= out_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         in_ready_r  <= (fsm_nxt_s == IDLE);
         busy_r      <= (fsm_nxt_s != IDLE);
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out       = out_r;
   assign busy      = busy_r;
   assign round_idx = round_r;

endmodule

// File: tb/tb_aes_iter_sequencer.sv
// Self-checking bench for aes_iter_sequencer: FIPS-197 vectors, random blocks against a
// GF(2^8)-derived AES reference, backpressure, busy rejection, mid-block reset, back-to-back.
module tb_aes_iter_sequencer;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
   logic [127:0] pt, key, ct;
   logic [3:0]   round_idx;

   aes_iter_sequencer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(pt), .key(key),
      .out_valid(out_valid), .out_ready(out_ready), .out(ct), .busy(busy), .round_idx(round_idx)
   );

   always #5 clk = ~clk;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   typedef struct {
      logic [127:0] pt;
      logic [127:0] key;
      logic [127:0] ct;
   } vec_t;

   int         n_checks = 0;
   int         n_pass = 0;
   logic [7:0] sbox_tab [256];
   vec_t       vecs [6];

   // ---------------- reference model ----------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, v;
      for (int n = 0; n < 256; n++) begin
         v   = 8'(n);
         inv = 8'h01;
         if (v == 8'h00) inv = 8'h00;
         else for (int e = 0; e < 254; e++) inv = gf_mul(inv, v);
         sbox_tab[n] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                       ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
      logic [31:0]  w [44];
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]], sbox_tab[tmp[31:24]]}
                  ^ {rc, 24'h000000};
            rc = gf_mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) s[r][c] = p[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r][c] = sbox_tab[s[r][(c+r)%4]];
         for (int c = 0; c < 4; c++) begin
            if (rnd < 10) begin
               s[0][c] = gf_mul(8'h02, t[0][c]) ^ gf_mul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
               s[1][c] = t[0][c] ^ gf_mul(8'h02, t[1][c]) ^ gf_mul(8'h03, t[2][c]) ^ t[3][c];
               s[2][c] = t[0][c] ^ t[1][c] ^ gf_mul(8'h02, t[2][c]) ^ gf_mul(8'h03, t[3][c]);
               s[3][c] = gf_mul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gf_mul(8'h02, t[3][c]);
            end else begin
               for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
            end
            for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
         end
      end
      res = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = s[r][c];
      return res;
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [127:0] p, input logic [127:0] k, input bit hold);
      int g = 0;
      while (!in_ready && g < 40) begin tick(); g++; end
      pt = p; key = k; in_valid = 1'b1;
      tick();
      if (!hold) in_valid = 1'b0;
      check("accept", {busy, in_ready, round_idx}, {1'b1, 1'b0, 4'd1});
   endtask

   task automatic wait_out(inout int n);
      while (!out_valid && n < 40) begin tick(); n++; end
   endtask

   task automatic finish_block(input string name, input logic [127:0] exp, input int start);
      int n = start;
      wait_out(n);
      if (start == 0) check({name, "_latency"}, 128'(n), 128'd10);
      check({name, "_ct"}, ct, exp);
      check({name, "_idx"}, {out_valid, busy, round_idx}, {1'b1, 1'b1, 4'd10});
      tick();
      check({name, "_post"}, {out_valid, in_ready, busy, round_idx}, {1'b0, 1'b1, 1'b0, 4'd0});
      check({name, "_keep"}, ct, exp);
   endtask

   task automatic run_until_idx(input logic [3:0] idx);
      int g = 0;
      while (round_idx != idx && g < 40) begin tick(); g++; end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int n;
      logic [127:0] rp, rk;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; pt = '0; key = '0;
      build_sbox();
      vecs[0] = '{C1_PT, C1_KEY, C1_CT};
      vecs[1] = '{B_PT, B_KEY, B_CT};
      for (int i = 2; i < 6; i++) begin
         vecs[i].pt  = {$urandom, $urandom, $urandom, $urandom};
         vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
         vecs[i].ct  = aes_ref(vecs[i].pt, vecs[i].key);
      end
      tick(); tick();
      check("reset_ctl", {in_ready, out_valid, busy, round_idx}, {1'b1, 1'b0, 1'b0, 4'd0});
      check("reset_out", ct, 128'd0);
      rst = 1'b0;
      tick();
      check("idle_ctl", {in_ready, out_valid, busy, round_idx}, {1'b1, 1'b0, 1'b0, 4'd0});

      for (int i = 0; i < 6; i++) begin
         accept(vecs[i].pt, vecs[i].key, 1'b0);
         finish_block($sformatf("vec%0d", i), vecs[i].ct, 0);
      end

      // FIPS-197 B with round-key tracking
      accept(B_PT, B_KEY, 1'b0);
      tick();
      check("b_rk1", dut.rk_r, 128'ha0fafe1788542cb123a339392a6c7605);
      check("b_idx2", 128'(round_idx), 128'd2);
      n = 1;
      wait_out(n);
      check("b_latency", 128'(n), 128'd10);
      check("b_rk10", dut.rk_r, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      finish_block("b", B_CT, 10);

      // Backpressure: hold out_ready low for 20 cycles after completion
      out_ready = 1'b0;
      accept(C1_PT, C1_KEY, 1'b0);
      n = 0;
      wait_out(n);
      check("bp_latency", 128'(n), 128'd10);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("bp_ctl", {out_valid, in_ready, busy}, {1'b1, 1'b0, 1'b1});
         check("bp_out", ct, C1_CT);
      end
      out_ready = 1'b1;
      tick();
      check("bp_release", {out_valid, in_ready, busy, round_idx}, {1'b0, 1'b1, 1'b0, 4'd0});

      // Random blocks with random output stalls
      for (int i = 0; i < 4; i++) begin
         rp = {$urandom, $urandom, $urandom, $urandom};
         rk = {$urandom, $urandom, $urandom, $urandom};
         out_ready = 1'b0;
         accept(rp, rk, 1'b0);
         n = 0;
         wait_out(n);
         for (int s = 0; s < int'($urandom_range(0, 5)); s++) tick();
         out_ready = 1'b1;
         finish_block($sformatf("rnd%0d", i), aes_ref(rp, rk), 10);
      end

      // Input offered while busy is ignored
      accept(C1_PT, C1_KEY, 1'b0);
      run_until_idx(4'd5);
      pt = {$urandom, $urandom, $urandom, $urandom};
      key = B_KEY;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("rej_idx", 128'(round_idx), 128'd6);
      finish_block("rej", C1_CT, 10);

      // Reset in the middle of a block
      accept(B_PT, B_KEY, 1'b0);
      run_until_idx(4'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_ctl", {in_ready, out_valid, busy, round_idx}, {1'b1, 1'b0, 1'b0, 4'd0});
      check("rst_mid_out", ct, 128'd0);
      accept(C1_PT, C1_KEY, 1'b0);
      finish_block("after_rst", C1_CT, 0);

      // Back-to-back with in_valid held high
      accept(C1_PT, C1_KEY, 1'b1);
      pt = B_PT; key = B_KEY;
      finish_block("b2b_first", C1_CT, 0);
      tick();
      check("b2b_accept2", {busy, in_ready, round_idx}, {1'b1, 1'b0, 4'd1});
      in_valid = 1'b0;
      finish_block("b2b_second", B_CT, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
